// File: rtl/subtractor_16bit.sv
// subtractor_16bit: registered 16-bit two's-complement subtractor (A - B)
// with a signed-overflow flag. The difference is formed as A + ~B + 1 on a
// ripple-carry chain of full adders; results are registered one cycle later.
module subtractor_16bit (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] sum,
   output logic        overflow
);

   localparam int unsigned W = 16;

   logic [W-1:0] b_inv;
   logic [W:0]   carry;
   logic [W-1:0] sum_d;
   logic         overflow_d;
   logic [W-1:0] sum_q;
   logic         overflow_q;

   // Ripple-carry chain computing A + ~B + 1; carry[i] is the carry into bit i
   always_comb begin
      b_inv      = ~B;
      carry      = '0;
      sum_d      = '0;
      carry[0]   = 1'b1;
      for (int i = 0; i < int'(W); i++) begin
         sum_d[i]     = A[i] ^ b_inv[i] ^ carry[i];
         carry[i+1]   = (A[i] & b_inv[i]) | (carry[i] & (A[i] ^ b_inv[i]));
      end
      // Signed overflow: carry into the sign bit disagrees with carry out of it
      overflow_d = carry[W-1] ^ carry[W];
   end

   // Output registers; async reset clears them without needing a clock edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         sum_q      <= sum_d;
         overflow_q <= overflow_d;
      end
   end

   assign sum      = sum_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_subtractor_16bit.sv
// Self-checking bench for subtractor_16bit: directed corner cases plus a
// randomized back-to-back run against an integer-arithmetic reference model.
module tb_subtractor_16bit;

   logic        clk;
   logic        rst;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] sum;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   subtractor_16bit dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .sum      (sum),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: true signed difference, then wrap and range-check
   function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
      int d;
      d = int'($signed(a)) - int'($signed(b));
      return 16'(d);
   endfunction

   function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b);
      int d;
      d = int'($signed(a)) - int'($signed(b));
      return (d > 32767) || (d < -32768);
   endfunction

   // Drive operands at the falling edge, then step to just after the next rising edge
   task automatic apply(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      A = a;
      B = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Outputs cleared from time zero even though operands are X
      #1;
      n_checks++;
      if (sum !== 16'h0000 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_initial: sum=%h ovf=%b, required sum=0000 ovf=0", sum, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      apply(16'h1234, 16'h0034);
      n_checks++;
      if (sum !== 16'h1200 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_preload: sum=%h ovf=%b, required sum=1200 ovf=0", sum, overflow);
      end
      // Assert reset mid-cycle with nonzero operands; must clear without an edge
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (sum !== 16'h0000 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: sum=%h ovf=%b, required sum=0000 ovf=0", sum, overflow);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (sum !== 16'h0000 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: sum=%h ovf=%b, required sum=0000 ovf=0", sum, overflow);
      end
      // Release: first edge afterwards loads the held operands
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (sum !== 16'h1200 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: sum=%h ovf=%b, required sum=1200 ovf=0", sum, overflow);
      end
   endtask

   task automatic test_directed();
      logic [15:0] ta [10];
      logic [15:0] tb [10];
      logic [15:0] ts [10];
      logic        tv [10];
      ta = '{16'h0002, 16'h0005, 16'h0004, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000};
      tb = '{16'h0002, 16'hFFFE, 16'h0000, 16'hFFFE, 16'h0002, 16'hFFFF, 16'hFFFE, 16'h0001, 16'h8000, 16'h8000};
      ts = '{16'h0000, 16'h0007, 16'h0004, 16'h0000, 16'h7FFD, 16'h8001, 16'h8001, 16'h7FFF, 16'h8000, 16'h0000};
      tv = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
      for (int i = 0; i < 10; i++) begin
         apply(ta[i], tb[i]);
         n_checks++;
         if (sum !== ts[i] || overflow !== tv[i]) begin
            n_fail++;
            $display("FAIL directed_%0d (%h-%h): sum=%h ovf=%b, required sum=%h ovf=%b",
                     i, ta[i], tb[i], sum, overflow, ts[i], tv[i]);
         end
      end
   endtask

   task automatic test_hold();
      apply(16'h7FFF, 16'hFFFE);
      // Operands change between edges; outputs must not follow them
      @(negedge clk);
      A = 16'h0001;
      B = 16'h0001;
      #1;
      n_checks++;
      if (sum !== 16'h8001 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_between_edges: sum=%h ovf=%b, required sum=8001 ovf=1", sum, overflow);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (sum !== 16'h0000 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_next_edge: sum=%h ovf=%b, required sum=0000 ovf=0", sum, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] corners [4];
      corners = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
      for (int cyc = 0; cyc < 1000; cyc++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if ($urandom_range(0, 7) == 0) a = corners[$urandom_range(0, 3)];
         if ($urandom_range(0, 7) == 0) b = corners[$urandom_range(0, 3)];
         if (cyc == 500) begin
            // Reset pulse mid-stream discards the in-flight result
            @(negedge clk);
            A   = a;
            B   = b;
            rst = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (sum !== 16'h0000 || overflow !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_reset: sum=%h ovf=%b, required sum=0000 ovf=0", sum, overflow);
            end
            @(negedge clk);
            rst = 1'b0;
         end
         apply(a, b);
         n_checks++;
         if (sum !== ref_sum(a, b) || overflow !== ref_ovf(a, b)) begin
            n_fail++;
            $display("FAIL b2b_cycle_%0d (%h-%h): sum=%h ovf=%b, required sum=%h ovf=%b",
                     cyc, a, b, sum, overflow, ref_sum(a, b), ref_ovf(a, b));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      A   = 'x;
      B   = 'x;
      test_reset();
      test_directed();
      test_hold();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/subtractor_16bit.md
# subtractor_16bit

Registered 16-bit two's-complement subtractor: computes `A - B` and flags signed overflow. It is the subtraction datapath of the project ALU and pairs with the 16-bit adder. Operands are sampled on each rising clock edge. The wrapped 16-bit difference and the overflow flag come from output registers, so downstream logic sees stable, glitch-free values.

## Interface
- No parameters; width fixed at 16 bits.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears output registers.
- `A`  input  16  minuend, signed two's complement.
- `B`  input  16  subtrahend, signed two's complement.
- `sum`  output  16  registered difference `A - B`, modulo 2^16.
- `overflow`  output  1  registered signed-overflow flag for the same operation as `sum`.
- One clock; reset is asynchronous and active-high.

## Operation
- Subtraction is `A + ~B + 1`.
  - Built as a 16-stage ripple-carry chain of full adders.
  - Every `B` bit is inverted.
  - Carry-in of bit 0 is tied to 1.
  - A behavioural `-` operator is not used.
- Difference bits `d[15:0]` are the full-adder sum outputs.
- Final carry-out is discarded; no borrow output.
- Result wraps modulo 2^16. `sum` always holds the low 16 bits, even on overflow.
- Overflow is the carry into bit 15 XOR the carry out of bit 15. Equivalently, it is 1 exactly when:
  - `A[15] != B[15]`, and
  - `d[15] != A[15]`.
- Overflow cases:
  - positive minus negative giving a negative result;
  - negative minus positive giving a positive result.
- Same-sign operands never overflow.
- `B = 0x8000` (-32768) gets no special case; the standard rule applies. Example: `0x0000 - 0x8000` gives `sum=0x8000`, `overflow=1`.
- Unsigned borrow is not reported. `overflow` covers signed interpretation only.
- No state beyond the two output registers.
- No enable: every rising edge captures a new result.

## Timing
- Combinational path: `A`, `B` through the 16-bit ripple chain to the D inputs of the `sum`/`overflow` registers.
- Latency 1 cycle. Operands stable before rising edge N appear on `sum`/`overflow` right after edge N and hold until edge N+1.
- Throughput: one subtraction per cycle; back-to-back operand changes are allowed every cycle.
- `rst` asserted:
  - `sum` goes to `0x0000` and `overflow` to 0 immediately, with no clock edge needed.
  - Both hold while `rst` is high, regardless of clock or operands.
- `rst` deasserted: the first rising edge afterwards captures the current `A`, `B`.
- Reset mid-stream: any in-flight result is discarded. No partial or stale value appears after release.
- Operands that change between edges have no effect on outputs until the next edge.
- Outputs never show X once reset has been applied, even if inputs were X before reset.

## Test plan
- Reset: assert `rst` asynchronously with nonzero operands held -> `sum=0x0000`, `overflow=0` without a clock edge. Release -> the next edge loads the result.
- Basic cases, each checked one cycle after applying, all `overflow=0`:
  - `0x0002 - 0x0002` -> `sum=0x0000`
  - `0x0005 - 0xFFFE` (5 - (-2)) -> `sum=0x0007`
  - `0x0004 - 0x0000` -> `sum=0x0004`
  - `0xFFFE - 0xFFFE` -> `sum=0x0000`
- Near limits, no overflow:
  - `0x7FFF - 0x0002` -> `sum=0x7FFD` (32765), `overflow=0`
  - `0x8000 - 0xFFFF` -> `sum=0x8001` (-32767), `overflow=0`
- Positive minus negative overflow: `0x7FFF - 0xFFFE` -> `sum=0x8001`, `overflow=1`.
- Negative minus positive overflow: `0x8000 - 0x0001` -> `sum=0x7FFF`, `overflow=1`. Also `0x0000 - 0x8000` -> `sum=0x8000`, `overflow=1`.
- Back-to-back: a new operand pair every cycle for 1000 random cycles. Each output must equal the golden `(A-B) mod 2^16` and sign-rule overflow of the pair sampled on the previous edge. Include one `rst` pulse mid-run.
